// File: rtl/fir_cas_pkg.sv
// Shared definitions for the cascaded transposed-form 19-tap symmetric FIR:
// widths, the tap-to-product mapping and the coefficient list.
package fir_cas_pkg;

    localparam int PROD_W       = 20;
    localparam int ACC_W_DEF    = 24;
    localparam int OUT_W_DEF    = 20;
    localparam int FILL_LEN_DEF = 19;
    localparam int NUM_TAPS     = 19;
    localparam int NUM_REGS     = 18;

    typedef enum logic [3:0] {
        SRC_ZERO,
        SRC_P10,
        SRC_P11,
        SRC_P13,
        SRC_P15,
        SRC_P17,
        SRC_P19,
        SRC_NEG8,
        SRC_NEG12
    } prod_src_e;

    typedef struct packed {
        logic [PROD_W-1:0] p10;
        logic [PROD_W-1:0] p11;
        logic [PROD_W-1:0] p13;
        logic [PROD_W-1:0] p15;
        logic [PROD_W-1:0] p17;
        logic [PROD_W-1:0] p19;
        logic [PROD_W-1:0] neg8;
        logic [PROD_W-1:0] neg12;
    } prod_bus_t;

    // Index 0 is c1 ... index 18 is c19.
    localparam prod_src_e TAP_SRC [0:NUM_TAPS-1] = '{
        SRC_P19, SRC_ZERO, SRC_P17, SRC_ZERO, SRC_P15, SRC_P19, SRC_P13,
        SRC_NEG8, SRC_P11, SRC_P10, SRC_P11, SRC_NEG12, SRC_P13, SRC_P19,
        SRC_P15, SRC_ZERO, SRC_P17, SRC_ZERO, SRC_P19
    };

    localparam int COEF [0:NUM_TAPS-1] = '{
        1, 0, -3, 0, 13, 1, -40, -1, 157, 258, 157, -1, -40, 1, 13, 0, -3, 0, 1
    };

    function automatic logic [PROD_W-1:0] select_product(input prod_src_e src,
                                                         input prod_bus_t b);
        logic [PROD_W-1:0] r;
        r = '0;
        case (src)
            SRC_P10:   r = b.p10;
            SRC_P11:   r = b.p11;
            SRC_P13:   r = b.p13;
            SRC_P15:   r = b.p15;
            SRC_P17:   r = b.p17;
            SRC_P19:   r = b.p19;
            SRC_NEG8:  r = b.neg8;
            SRC_NEG12: r = b.neg12;
            default:   r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cas_acc_stage.sv
// One register of the transposed delay chain; adds its sign-extended tap
// product to the upstream chain value unless the tap coefficient is zero.
module cas_acc_stage
    import fir_cas_pkg::*;
#(
    parameter int ACC_W   = ACC_W_DEF,
    parameter bit HAS_TAP = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              enable,
    input  logic [ACC_W-1:0]  chain_in,
    input  logic [PROD_W-1:0] tap,
    output logic [ACC_W-1:0]  chain_out
);

    logic [ACC_W-1:0] next_val;

    generate
        if (HAS_TAP) begin : g_tap
            assign next_val = chain_in + {{(ACC_W-PROD_W){tap[PROD_W-1]}}, tap};
        end else begin : g_pass
            logic unused_tap;
            assign unused_tap = ^tap;
            assign next_val   = chain_in;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            chain_out <= '0;
        end else if (enable) begin
            chain_out <= next_val;
        end
    end

endmodule

// File: rtl/output_ctrl_cas.sv
// FIR output stage: 18-register transposed accumulation chain, saturated
// registered output, and pipeline-fill valid flag.
module output_ctrl_cas
    import fir_cas_pkg::*;
#(
    parameter int ACC_W    = ACC_W_DEF,
    parameter int OUT_W    = OUT_W_DEF,
    parameter int FILL_LEN = FILL_LEN_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clk_enable,
    input  logic                    flush,
    input  logic [PROD_W-1:0]       product10,
    input  logic [PROD_W-1:0]       product11,
    input  logic [PROD_W-1:0]       product13,
    input  logic [PROD_W-1:0]       product15,
    input  logic [PROD_W-1:0]       product17,
    input  logic [PROD_W-1:0]       product19,
    input  logic [PROD_W-1:0]       negproduct8,
    input  logic [PROD_W-1:0]       negproduct12,
    output logic signed [OUT_W-1:0] filter_out,
    output logic                    out_valid,
    output logic                    sat_flag
);

    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    localparam logic [4:0] FILL_MAX = 5'(FILL_LEN);

    prod_bus_t         prods;
    logic [PROD_W-1:0] tap_prod [0:NUM_TAPS-1];
    logic [ACC_W-1:0]  chain    [1:NUM_TAPS];

    assign prods = '{p10: product10, p11: product11, p13: product13,
                     p15: product15, p17: product17, p19: product19,
                     neg8: negproduct8, neg12: negproduct12};

    // chain[k] is s_k; chain[19] is the zero that feeds s18.
    assign chain[NUM_TAPS] = '0;

    generate
        for (genvar t = 0; t < NUM_TAPS; t++) begin : g_tapsel
            assign tap_prod[t] = select_product(TAP_SRC[t], prods);
        end
        for (genvar k = 1; k <= NUM_REGS; k++) begin : g_chain
            cas_acc_stage #(
                .ACC_W   (ACC_W),
                .HAS_TAP (TAP_SRC[k] != SRC_ZERO)
            ) u_stage (
                .clk       (clk),
                .reset     (reset),
                .clear     (flush),
                .enable    (clk_enable),
                .chain_in  (chain[k+1]),
                .tap       (tap_prod[k]),
                .chain_out (chain[k])
            );
        end
    endgenerate

    logic signed [ACC_W-1:0] y;
    logic [OUT_W-1:0]        sat_val;
    logic                    sat_hit;

    assign y = $signed(chain[1] + {{(ACC_W-PROD_W){tap_prod[0][PROD_W-1]}}, tap_prod[0]});

    always_comb begin
        sat_val = y[OUT_W-1:0];
        sat_hit = 1'b0;
        if (y > SAT_MAX) begin
            sat_val = SAT_MAX[OUT_W-1:0];
            sat_hit = 1'b1;
        end else if (y < SAT_MIN) begin
            sat_val = SAT_MIN[OUT_W-1:0];
            sat_hit = 1'b1;
        end
    end

    logic [4:0] fill_cnt;
    logic [4:0] fill_next;

    assign fill_next = (fill_cnt == FILL_MAX) ? fill_cnt : fill_cnt + 5'd1;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            fill_cnt   <= '0;
            filter_out <= '0;
            out_valid  <= 1'b0;
            sat_flag   <= 1'b0;
        end else if (clk_enable) begin
            fill_cnt   <= fill_next;
            filter_out <= sat_val;
            out_valid  <= (fill_next == FILL_MAX);
            sat_flag   <= sat_hit;
        end
    end

endmodule

// File: tb/tb_output_ctrl_cas.sv
// Bench for output_ctrl_cas: a 20-bit and a 16-bit output instance share one
// product stimulus and are checked against a direct-form convolution model.
module tb_output_ctrl_cas;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clk_enable = 1'b0;
    logic        flush = 1'b0;
    logic [19:0] p10, p11, p13, p15, p17, p19, neg8, neg12;
    int          x_cur;

    logic signed [19:0] fo20;
    logic signed [15:0] fo16;
    logic               valid20, valid16, sat20, sat16;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    output_ctrl_cas #(.ACC_W(24), .OUT_W(20), .FILL_LEN(19)) dut20 (
        .clk(clk), .reset(reset), .clk_enable(clk_enable), .flush(flush),
        .product10(p10), .product11(p11), .product13(p13), .product15(p15),
        .product17(p17), .product19(p19), .negproduct8(neg8), .negproduct12(neg12),
        .filter_out(fo20), .out_valid(valid20), .sat_flag(sat20));

    output_ctrl_cas #(.ACC_W(24), .OUT_W(16), .FILL_LEN(19)) dut16 (
        .clk(clk), .reset(reset), .clk_enable(clk_enable), .flush(flush),
        .product10(p10), .product11(p11), .product13(p13), .product15(p15),
        .product17(p17), .product19(p19), .negproduct8(neg8), .negproduct12(neg12),
        .filter_out(fo16), .out_valid(valid16), .sat_flag(sat16));

    // Impulse response of the filter, c1..c19, followed by one trailing zero.
    int COEFS [19] = '{1, 0, -3, 0, 13, 1, -40, -1, 157, 258, 157, -1, -40, 1, 13, 0, -3, 0, 1};
    int IMP   [20] = '{1, 0, -3, 0, 13, 1, -40, -1, 157, 258, 157, -1, -40, 1, 13, 0, -3, 0, 1, 0};

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic int sat_to(input int y, input int w);
        int mx = (1 << (w - 1)) - 1;
        int mn = -(1 << (w - 1));
        if (y > mx) return mx;
        if (y < mn) return mn;
        return y;
    endfunction

    // Reference model: keeps the enabled samples seen since the last clear
    // and convolves them with the coefficient list.
    int  hist [18];
    int  m_cnt = 0;
    int  m_out20 = 0, m_out16 = 0;
    bit  m_valid = 0, m_sat20 = 0, m_sat16 = 0;
    bit  m_init = 0;

    always @(posedge clk) begin
        int y;
        m_init <= 1'b1;
        if (reset || flush) begin
            for (int i = 0; i < 18; i++) hist[i] <= 0;
            m_cnt   <= 0;
            m_out20 <= 0;
            m_out16 <= 0;
            m_valid <= 0;
            m_sat20 <= 0;
            m_sat16 <= 0;
        end else if (clk_enable) begin
            y = COEFS[0] * x_cur;
            for (int i = 1; i < 19; i++) y += COEFS[i] * hist[i-1];
            hist[0] <= x_cur;
            for (int i = 1; i < 18; i++) hist[i] <= hist[i-1];
            m_out20 <= sat_to(y, 20);
            m_out16 <= sat_to(y, 16);
            m_sat20 <= (sat_to(y, 20) != y);
            m_sat16 <= (sat_to(y, 16) != y);
            m_cnt   <= (m_cnt < 19) ? m_cnt + 1 : 19;
            m_valid <= (m_cnt + 1 >= 19);
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            check("model_fo20",    fo20,    m_out20);
            check("model_valid20", valid20, m_valid);
            check("model_sat20",   sat20,   m_sat20);
            check("model_fo16",    fo16,    m_out16);
            check("model_valid16", valid16, m_valid);
            check("model_sat16",   sat16,   m_sat16);
        end
    end

    task automatic set_x(input int xv);
        x_cur = xv;
        p10   = 20'(258 * xv);
        p11   = 20'(157 * xv);
        p13   = 20'(-40 * xv);
        p15   = 20'(13 * xv);
        p17   = 20'(-3 * xv);
        p19   = 20'(xv);
        neg8  = 20'(-xv);
        neg12 = 20'(-xv);
    endtask

    task automatic cyc(input int xv, input bit en, input bit fl, input bit rs);
        @(negedge clk);
        set_x(xv);
        clk_enable = en;
        flush      = fl;
        reset      = rs;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int idx;
        int prev_fo;
        bit prev_v;
        bit en;

        set_x(0);
        cyc(0, 1'b1, 1'b0, 1'b1);
        cyc(0, 1'b1, 1'b0, 1'b1);
        check("reset_fo",    fo20,    0);
        check("reset_valid", valid20, 0);
        check("reset_sat",   sat20,   0);

        // Impulse
        cyc(1, 1'b1, 1'b0, 1'b0);
        check("imp_0", fo20, IMP[0]);
        for (int i = 1; i < 20; i++) begin
            cyc(0, 1'b1, 1'b0, 1'b0);
            check($sformatf("imp_%0d", i), fo20, IMP[i]);
            check($sformatf("imp_valid_%0d", i), valid20, (i >= 18) ? 1 : 0);
        end

        // Impulse with clk_enable gated every third cycle
        cyc(0, 1'b0, 1'b1, 1'b0);
        check("flush_fo",    fo20,    0);
        check("flush_valid", valid20, 0);
        idx = 0; prev_fo = 0; prev_v = 0;
        for (int c = 0; idx < 20 && c < 60; c++) begin
            en = (c % 3 != 1);
            cyc((idx == 0) ? 1 : 0, en, 1'b0, 1'b0);
            if (en) begin
                check($sformatf("gate_imp_%0d", idx), fo20, IMP[idx]);
                prev_fo = IMP[idx];
                prev_v  = (idx >= 18);
                idx++;
            end else begin
                check("gate_hold_fo",    fo20,    prev_fo);
                check("gate_hold_valid", valid20, prev_v);
            end
        end

        // Step x = -512
        cyc(0, 1'b0, 1'b1, 1'b0);
        for (int n = 1; n <= 19; n++) begin
            cyc(-512, 1'b1, 1'b0, 1'b0);
            check($sformatf("step_valid_%0d", n), valid20, (n == 19) ? 1 : 0);
        end
        check("step_fo20",  fo20,  -263168);
        check("step_sat20", sat20, 0);
        check("step_fo16",  fo16,  -32768);
        check("step_sat16", sat16, 1);

        // Flush together with clk_enable at sample 10
        cyc(0, 1'b0, 1'b1, 1'b0);
        for (int n = 1; n <= 9; n++) cyc(-512, 1'b1, 1'b0, 1'b0);
        cyc(-512, 1'b1, 1'b1, 1'b0);
        check("flushen_fo",    fo20,    0);
        check("flushen_valid", valid20, 0);
        for (int n = 1; n <= 19; n++) begin
            cyc(-512, 1'b1, 1'b0, 1'b0);
            check($sformatf("refill_valid_%0d", n), valid20, (n == 19) ? 1 : 0);
        end
        check("refill_fo", fo20, -263168);

        // Reset mid-stream
        for (int n = 1; n <= 7; n++) cyc(-512, 1'b1, 1'b0, 1'b0);
        cyc(-512, 1'b1, 1'b0, 1'b1);
        check("midrst_fo",    fo20,    0);
        check("midrst_valid", valid20, 0);
        check("midrst_sat16", sat16,   0);
        for (int n = 1; n <= 19; n++) begin
            cyc(-512, 1'b1, 1'b0, 1'b0);
            check($sformatf("postrst_valid_%0d", n), valid20, (n == 19) ? 1 : 0);
        end
        check("postrst_fo", fo20, -263168);

        // Positive saturation, x = 511
        cyc(0, 1'b0, 1'b1, 1'b0);
        for (int n = 1; n <= 19; n++) cyc(511, 1'b1, 1'b0, 1'b0);
        check("satpos_fo20",  fo20,  262654);
        check("satpos_sat20", sat20, 0);
        check("satpos_fo16",  fo16,  32767);
        check("satpos_sat16", sat16, 1);

        cyc(0, 1'b1, 1'b0, 1'b0);
        cyc(0, 1'b1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/output_ctrl_cas.md
# output_ctrl_cas

Output side of the cascaded transposed-form 19-tap symmetric FIR: takes the per-coefficient product buses from the input control block and accumulates them through an 18-register transposed delay chain. Emits a registered, saturated `filter_out` with a pipeline-fill `out_valid` flag. Sits directly downstream of the input control stage in each cascade section, on the same clock and clock enable.

## Interface
- `ACC_W`, 24, accumulator/chain register width; sign-extended products; must be ≥ 21.
- `OUT_W`, 20, `filter_out` width; saturated from `ACC_W`; must be ≤ `ACC_W`.
- `FILL_LEN`, 19, enabled samples after reset/flush before `out_valid` rises.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `clk_enable` in 1: sample strobe; chain and output advance only when high.
- `flush` in 1: synchronous chain clear.
- `product10`, `product11`, `product13`, `product15`, `product17`, `product19`, `negproduct8`, `negproduct12` in 20 each: signed products of the current input sample; integer-LSB aligned.
- `filter_out` out `OUT_W`: signed filter output, registered.
- `out_valid` out 1: high once the chain holds `FILL_LEN` real samples.
- `sat_flag` out 1: registered; high when the current `filter_out` was clipped.

## Operation
- Tap mapping, c1..c19 (symmetric):
  - c1, c19, c6, c14 → `product19`
  - c2, c4, c16, c18 → 0 (no adder)
  - c3, c17 → `product17`; c5, c15 → `product15`; c7, c13 → `product13`
  - c8 → `negproduct8`; c12 → `negproduct12`
  - c9, c11 → `product11`; c10 → `product10`
- Chain registers s1..s18, each `ACC_W` bits:
  - On enabled edge: s18 ← p(c19); s_k ← s_{k+1} + p(c_{k+1}) for k = 1..17.
  - Zero taps pass through with no adder.
  - y = p(c1) + s1 (computed before the edge).
- Width rule: products sign-extended to `ACC_W`. Worst-case |y| = 690·512 = 353280, so no internal overflow is possible at `ACC_W` ≥ 21.
- Output saturation:
  - y > 2^(OUT_W−1)−1 → `filter_out` = max positive, `sat_flag` = 1.
  - y < −2^(OUT_W−1) → `filter_out` = min negative, `sat_flag` = 1.
  - Otherwise `filter_out` = y[OUT_W−1:0], `sat_flag` = 0.
- Fill counter: 5 bits.
  - Increments on each enabled edge, saturates at `FILL_LEN`.
  - `out_valid` = (count == `FILL_LEN`), registered.
- Reset value of every output: `filter_out` = 0, `out_valid` = 0, `sat_flag` = 0. Chain registers and counter also clear to 0.
- Flush: clears chain, counter, `filter_out`, `out_valid` and `sat_flag`, independent of `clk_enable`.
- Priority: `reset` > `flush` > `clk_enable`. Flush with `clk_enable` high discards that sample.
- `clk_enable` low: every register holds, including `out_valid` and `sat_flag`.

## Timing
- Products are combinational from the upstream input register. They must be stable for the enabled edge that follows the upstream capture.
- Latency: the enabled edge that sees sample n's products updates `filter_out` with y[n]. That is one enabled edge after the upstream capture, two after `filter_in` is presented.
- `out_valid` rises on the 19th enabled edge after reset/flush, the same edge that presents the first fully-populated output.
- `sat_flag` is aligned to its `filter_out` value.
- Reset mid-stream: outputs are 0 on the edge after `reset` goes high. The first enabled edge after release restarts the fill count at 1.

## Structure
- Shared package `fir_cas_pkg`:
  - tap-to-product mapping constants and the coefficient list (for the bench model)
  - product width 20, default `ACC_W`/`OUT_W`
  - `FILL_LEN`
- Sub-module `cas_acc_stage`:
  - one chain register with optional adder (parameter `HAS_TAP`)
  - clear/enable inputs
  - instantiated 18 times via generate
- Saturation is inline in the top module.

## Test plan
- Impulse: drive products for x=1 (p10=258, p11=157, p13=−40, p15=13, p17=−3, p19=1, neg=−1) for one enabled cycle, then zeros.
  - `filter_out` = 1,0,−3,0,13,1,−40,−1,157,258,157,−1,−40,1,13,0,−3,0,1, then 0.
- Step: x=−512 held.
  - Settles to −263168 on the 19th enabled edge.
  - `out_valid` rises on that same edge; `sat_flag` stays 0.
- Saturation: `OUT_W`=16, x=511 held.
  - Steady y = 262654, so `filter_out` = 32767 with `sat_flag` = 1.
  - x=−512 held gives −32768 with `sat_flag` = 1.
- Enable gating: toggle `clk_enable` 1-0-1 during the impulse test.
  - Output sequence is unchanged, only stretched.
  - Outputs and `out_valid` hold while disabled.
- Flush vs enable: assert `flush` and `clk_enable` together at sample 10 of the step test.
  - Next edge: `filter_out` = 0, `out_valid` = 0.
  - Refill completes after 19 more enabled edges.
- Reset mid-stream: assert `reset` one cycle during the step test.
  - All outputs 0 on the next edge.
  - Behaviour afterwards matches a fresh start.
